seq_detect_param: RTL

Parametrised, runtime-programmable Moore sequence detector that generalises the fixed-pattern serial detector. Samples a qualified serial bit stream and asserts a one-cycle registered match flag when the last PAT_LEN bits equal a programmed pattern. Supports overlapping and non-overlapping detection and an optional saturating match counter. Sits on a serial-receive front end as a framing/keyword detector.

---
 rtl/seq_detect_param_pkg.sv | 21 ++
 rtl/seq_detect_param_if.sv | 43 ++++
 rtl/seq_detect_param_cnt.sv | 23 ++
 rtl/seq_detect_param.sv | 90 +++++++++
 4 files changed

// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Optional match counter is enabled with SEQ_DETECT_MATCH_COUNT_EN.
package seq_detect_pkg;

  localparam int LEN_LIMIT = 32;
  localparam logic CFG_ERR_RESET = 1'b1;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [LEN_LIMIT-1:0] len_mask(
    input int unsigned len
  );
    logic [LEN_LIMIT-1:0] one;
    one = 1;
    if (len >= LEN_LIMIT) return '1;
    return (one << len) - one;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Config/stream bundle for seq_detect_param.
// Counter signals exist only with SEQ_DETECT_MATCH_COUNT_EN.
interface seq_detect_param_if
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = 8
);
  logic               CFG_LOAD;
  logic [MAX_LEN-1:0] PATTERN;
  logic [LEN_W-1:0]   PAT_LEN;
  logic               OVERLAP;
  logic               DIN_VALID;
  logic               DIN;
  logic               DOUT;
  logic               CFG_ERR;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [CNT_W-1:0]   MATCH_CNT;
  logic               CNT_CLR;
`endif

  modport master (
    output CFG_LOAD, PATTERN, PAT_LEN,
    output OVERLAP, DIN_VALID, DIN,
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    output CNT_CLR,
    input  MATCH_CNT,
`endif
    input  DOUT, CFG_ERR
  );

  modport slave (
    input  CFG_LOAD, PATTERN, PAT_LEN,
    input  OVERLAP, DIN_VALID, DIN,
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    input  CNT_CLR,
    output MATCH_CNT,
`endif
    output DOUT, CFG_ERR
  );

endinterface

// File: rtl/seq_detect_param_cnt.sv
// Saturating match counter with synchronous clear (clear beats increment).
// Instantiated only when SEQ_DETECT_MATCH_COUNT_EN is defined.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable Moore serial pattern detector, one-cycle match pulse.
// SEQ_DETECT_MATCH_COUNT_EN adds a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = 8
) (
  input logic               CLK,
  input logic               RESET_N,
  seq_detect_param_if.slave bus
);

  logic [MAX_LEN-1:0]   hist;
  logic [MAX_LEN-1:0]   hist_next;
  logic [MAX_LEN-1:0]   pat_q;
  logic [MAX_LEN-1:0]   mask;
  logic [LEN_LIMIT-1:0] mask_full;
  logic [LEN_W-1:0]     fill;
  logic [LEN_W-1:0]     fill_next;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  logic                 cfg_err;
  logic                 dout;
  logic                 match;
  logic                 len_bad;

  always_comb begin
    hist_next = hist;
    fill_next = fill;
    if (bus.DIN_VALID) begin
      hist_next = {hist[MAX_LEN-2:0], bus.DIN};
      if (fill != LEN_W'(MAX_LEN)) begin
        fill_next = fill + LEN_W'(1);
      end
    end
  end

  assign mask_full = len_mask(32'(len_q));
  assign mask      = mask_full[MAX_LEN-1:0];

  assign match = bus.DIN_VALID && !cfg_err
              && (fill_next >= len_q)
              && (((hist_next ^ pat_q) & mask) == '0);

  assign len_bad = (bus.PAT_LEN == '0)
                || (bus.PAT_LEN > LEN_W'(MAX_LEN));

  // A config load discards any sample presented in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hist    <= '0;
      fill    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      dout    <= 1'b0;
      cfg_err <= CFG_ERR_RESET;
    end else if (bus.CFG_LOAD) begin
      pat_q   <= bus.PATTERN;
      len_q   <= bus.PAT_LEN;
      ovl_q   <= bus.OVERLAP;
      cfg_err <= len_bad;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
    end else begin
      hist <= hist_next;
      fill <= (match && !ovl_q) ? '0 : fill_next;
      dout <= match;
    end
  end

  assign bus.DOUT    = dout;
  assign bus.CFG_ERR = cfg_err;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (bus.CNT_CLR),
    .inc   (match && !bus.CFG_LOAD),
    .cnt   (bus.MATCH_CNT)
  );
`endif

endmodule
